// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared FSM states, default slice width and op encoding
package add_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int W_DEF = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_seq_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with registered pointer and one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr;
  // pointer breaks ties; a lone request always wins
  always_comb gnt = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
  // after a grant the pointer moves to the requester that lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (advance) ptr <= gnt[0];
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: arbitrates two requesters onto an external W-bit adder, one word per beat
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int NWORD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic                 r0_sub,
  input  logic [NWORD*W-1:0]   r0_a,
  input  logic [NWORD*W-1:0]   r0_b,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic                 r1_sub,
  input  logic [NWORD*W-1:0]   r1_a,
  input  logic [NWORD*W-1:0]   r1_b,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [NWORD*W-1:0]   rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);
  localparam int KW = NWORD > 1 ? $clog2(NWORD) : 1;
  state_t             state;
  logic [KW-1:0]      k;
  logic               carry, sub, acc, run, last;
  logic [NWORD*W-1:0] a, b;
  logic [W-1:0]       a_w, b_w;
  logic [1:0]         gnt;
  assign acc = (state == IDLE) && (r0_valid || r1_valid);
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({r1_valid, r0_valid}),
    .advance (acc),
    .gnt     (gnt)
  );
  // drive the current beat's slices to the adder, zero outside RUN
  always_comb begin
    run      = state == RUN;
    last     = k == KW'(NWORD - 1);
    a_w      = a[int'(k)*W +: W];
    b_w      = b[int'(k)*W +: W];
    add_a    = run ? a_w : '0;
    add_b    = run ? ((sub == OP_SUB) ? ~b_w : b_w) : '0;
    add_cin  = run && ((k == '0) ? sub : carry);
    r0_ready = (state == IDLE) && gnt[0];
    r1_ready = (state == IDLE) && gnt[1];
  end
  // IDLE latches the winner, RUN collects one word per beat, DONE holds the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      sub       <= 1'b0;
      a         <= '0;
      b         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else
      case (state)
        IDLE: if (acc) begin
          a      <= gnt[1] ? r1_a : r0_a;
          b      <= gnt[1] ? r1_b : r0_b;
          sub    <= gnt[1] ? r1_sub : r0_sub;
          rsp_id <= gnt[1];
          k      <= '0;
          state  <= RUN;
        end
        RUN: begin
          rsp_sum[int'(k)*W +: W] <= add_sum;
          carry <= add_cout;
          k     <= k + 1'b1;
          if (last) begin
            rsp_cout  <= add_cout;
            rsp_ovf   <= (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed vectors against add_seq_ctrl with a behavioural adder
module tb_add_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        r0_valid = 1'b0, r0_ready, r0_sub = 1'b0;
  logic        r1_valid = 1'b0, r1_ready, r1_sub = 1'b0;
  logic [63:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, rsp_ovf;
  logic [63:0] rsp_sum;
  int          n_chk = 0, n_fail = 0;

  add_seq_ctrl #(.W(32), .NWORD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_sub(r0_sub), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_sub(r1_sub), .r1_a(r1_a), .r1_b(r1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input logic [31:0] a_lo, input logic sub);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("beat0_add_a", add_a, a_lo);
        check("beat0_cin", add_cin, sub);
      end
    end while (!rsp_valid && n < 10);
    check("latency", n, 3);
  endtask

  task automatic op(input logic id, input logic sub, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] es, input logic ec, input logic eo);
    if (id) begin r1_valid = 1; r1_sub = sub; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1; r0_sub = sub; r0_a = a; r0_b = b; end
    @(negedge clk);
    check("grant", {r1_ready, r0_ready}, id ? 2'b10 : 2'b01);
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0;
    r0_a = 64'hDEAD_BEEF_DEAD_BEEF; r0_b = 64'h1234_5678_9ABC_DEF0;
    r1_a = 64'h0F0F_0F0F_0F0F_0F0F; r1_b = 64'hF0F0_F0F0_F0F0_F0F0;
    wait_rsp(a[31:0], sub);
    check("sum", rsp_sum, es);
    check("cout", rsp_cout, ec);
    check("ovf", rsp_ovf, eo);
    check("id", rsp_id, id);
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    check("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_id", rsp_id, 0);
    check("rst_flags", {rsp_cout, rsp_ovf}, 0);
    check("rst_adder", {add_a, add_b, add_cin}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    op(0, 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0);
    handshake();
    op(0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 1);
    handshake();
    op(1, 1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    handshake();
    // contention: pointer is back on r0
    r0_valid = 1; r0_sub = 0; r0_a = 64'd5;  r0_b = 64'd3;
    r1_valid = 1; r1_sub = 1; r1_a = 64'd10; r1_b = 64'd4;
    @(negedge clk);
    check("cont_g0", {r1_ready, r0_ready}, 2'b01);
    @(posedge clk);
    #1;
    wait_rsp(32'd5, 0);
    check("cont_id0", rsp_id, 0);
    check("cont_sum0", rsp_sum, 64'd8);
    check("cont_busy", {r1_ready, r0_ready}, 2'b00);
    handshake();
    @(negedge clk);
    check("cont_g1", {r1_ready, r0_ready}, 2'b10);
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0;
    wait_rsp(32'd10, 1);
    check("cont_id1", rsp_id, 1);
    check("cont_sum1", rsp_sum, 64'd6);
    check("cont_cout1", rsp_cout, 1);
    check("cont_ovf1", rsp_ovf, 0);
    handshake();
    // backpressure with a requester waiting
    op(0, 0, 64'd2, 64'd3, 64'd5, 0, 0);
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 64'd5);
      check("bp_ready", {r1_ready, r0_ready}, 2'b00);
    end
    r0_valid = 0; r1_valid = 0;
    handshake();
    // reset during beat 0
    r0_valid = 1; r0_sub = 0; r0_a = 64'd1; r0_b = 64'd1;
    @(posedge clk);
    #1;
    r0_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("ar_sum", rsp_sum, 0);
    check("ar_valid", rsp_valid, 0);
    check("ar_adder", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ar_no_rsp", rsp_valid, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
